// File: rtl/volume_sampler.sv
// Latch-strobe timer and sampler for the volume lc_dpll: strobes the LPF latch,
// captures lpf_i a fixed delay later and queues samples in a small show-ahead FIFO.
module volume_sampler #(
  parameter int DATA_W     = 32,
  parameter int DIV        = 48,
  parameter int SAMPLE_DLY = 2,
  parameter int DEPTH_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] lpf_i,
  output logic              ltch_o,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [DEPTH_W:0]  level_o,
  output logic              ovf_o
);

  localparam int DEPTH = 2 ** DEPTH_W;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [DEPTH_W:0] LVL_FULL = (DEPTH_W + 1)'(DEPTH);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ltch_q, ltch_d;
  logic [SAMPLE_DLY-1:0] dly_q, dly_d, dly_sh;
  logic [DATA_W-1:0]     smp_q, smp_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [DEPTH_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]      lvl_q, lvl_d;
  logic                  ovf_q, ovf_d;
  logic                  push, empty, full, pop_ok, push_ok;

  // Divider: held at zero while disabled so the first strobe lands DIV cycles after enable
  always_comb begin
    cnt_d  = cnt_q;
    ltch_d = 1'b0;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else begin
      ltch_d = (cnt_q == CNT_MAX);
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  generate
    if (SAMPLE_DLY == 1) begin : g_dly1
      assign dly_sh = ltch_q;
    end else begin : g_dlyn
      assign dly_sh = {dly_q[SAMPLE_DLY-2:0], ltch_q};
    end
  endgenerate

  // Capture lpf_i on the edge the strobe leaves the delay line; the FIFO write follows
  always_comb begin
    dly_d = clr_i ? '0 : dly_sh;
    smp_d = dly_d[SAMPLE_DLY-1] ? lpf_i : smp_q;
  end

  assign push    = dly_q[SAMPLE_DLY-1];
  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == LVL_FULL);
  assign pop_ok  = rd_i && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = smp_q;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !push_ok) ovf_d = 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      ltch_q   <= 1'b0;
      dly_q    <= '0;
      smp_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ltch_q   <= ltch_d;
      dly_q    <= dly_d;
      smp_q    <= smp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign ltch_o    = ltch_q;
  assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign empty_o   = empty;
  assign full_o    = full;
  assign level_o   = lvl_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_volume_sampler.sv
// Directed bench for volume_sampler with DIV=8, SAMPLE_DLY=2, DEPTH_W=2.
module tb_volume_sampler;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, rd;
  logic [31:0] lpf;
  logic        ltch, empty, full, ovf;
  logic [31:0] rd_data;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;

  volume_sampler #(.DATA_W(32), .DIV(8), .SAMPLE_DLY(2), .DEPTH_W(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr), .lpf_i(lpf),
    .ltch_o(ltch), .rd_i(rd), .rd_data_o(rd_data), .empty_o(empty),
    .full_o(full), .level_o(level), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; rd = 1'b0; lpf = 32'h0000_1234;
    tick(2);
    chk("rst_ltch", ltch, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);

    // first strobe after reset release
    rst_n = 1'b1;
    tick(7);  chk("ltch_e7", ltch, 0);
    tick(1);  chk("ltch_e8", ltch, 1);
    tick(1);  chk("ltch_e9", ltch, 0);
    chk("empty_e9", empty, 1);
    tick(1);  chk("empty_e10", empty, 1);
    tick(1);
    chk("lvl_e11", level, 1);
    chk("empty_e11", empty, 0);
    chk("data_e11", rd_data, 32'h0000_1234);
    rd = 1'b1; tick(1); rd = 1'b0;
    chk("pop_empty", empty, 1);
    chk("pop_data", rd_data, 0);
    chk("pop_level", level, 0);
    tick(4);  chk("ltch_e16", ltch, 1);

    // fill past depth with strobe index as the sample
    restart();
    for (int m = 1; m <= 6; m++) begin
      tick(8);
      lpf = 32'(m);
    end
    tick(3);
    en = 1'b0;
    chk("fill_level", level, 4);
    chk("fill_full", full, 1);
    chk("fill_ovf", ovf, 1);
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("fill_head%0d", v), rd_data, 64'(v));
      rd = 1'b1; tick(1); rd = 1'b0;
    end
    chk("drain_empty", empty, 1);
    chk("drain_data", rd_data, 0);
    chk("ovf_sticky", ovf, 1);

    // push and pop on the same edge while full
    restart();
    chk("clr_ovf", ovf, 0);
    chk("clr_level", level, 0);
    en = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      tick(8);
      lpf = 32'(m);
    end
    tick(2);
    rd = 1'b1; tick(1); rd = 1'b0; en = 1'b0;
    chk("pp_level", level, 4);
    chk("pp_full", full, 1);
    chk("pp_ovf", ovf, 0);
    for (int v = 2; v <= 5; v++) begin
      chk($sformatf("pp_head%0d", v), rd_data, 64'(v));
      rd = 1'b1; tick(1); rd = 1'b0;
    end
    chk("pp_empty", empty, 1);

    // pop while empty
    restart();
    rd = 1'b1; tick(3); rd = 1'b0;
    chk("epop_level", level, 0);
    chk("epop_ovf", ovf, 0);
    chk("epop_empty", empty, 1);
    en = 1'b1; lpf = 32'h0000_ABCD;
    tick(11);
    chk("epop_data", rd_data, 32'h0000_ABCD);
    chk("epop_lvl1", level, 1);

    // disable right after a strobe: in-flight sample still lands
    restart();
    lpf = 32'd77;
    tick(8);  chk("dis_ltch", ltch, 1);
    tick(1);  en = 1'b0;
    tick(2);
    chk("dis_level", level, 1);
    chk("dis_data", rd_data, 32'd77);
    seen = 1'b0;
    repeat (20) begin
      tick(1);
      if (ltch !== 1'b0) seen = 1'b1;
    end
    chk("dis_no_ltch", seen, 0);
    chk("dis_level2", level, 1);

    // clear while a strobe is in the delay line
    restart();
    en = 1'b1; lpf = 32'd99;
    tick(9);
    clr = 1'b1; tick(1); clr = 1'b0; en = 1'b0;
    tick(5);
    chk("clr_mid_level", level, 0);
    chk("clr_mid_empty", empty, 1);
    chk("clr_mid_ovf", ovf, 0);
    chk("clr_mid_ltch", ltch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
